// File: rtl/reservation_station_if.sv
// Dispatch, result-bus and issue signals of the reservation station.
// master: dispatcher/ROB side that drives dispatch and CDB; slave: the station.
interface reservation_station_if #(
    parameter int unsigned ROB_W = 4
) ();
    // Dispatch
    logic              disp_flag_in;
    logic [5:0]        disp_op_in;
    logic [31:0]       disp_val1_in;
    logic [31:0]       disp_val2_in;
    logic              disp_rdy1_in;
    logic              disp_rdy2_in;
    logic [ROB_W-1:0]  disp_q1_in;
    logic [ROB_W-1:0]  disp_q2_in;
    logic [ROB_W-1:0]  disp_idx_in_ROB_in;
    logic              full_out;
    // Result buses
    logic              alu_cdb_flag_in;
    logic [31:0]       alu_cdb_val_in;
    logic [ROB_W-1:0]  alu_cdb_idx_in;
    logic              lsb_cdb_flag_in;
    logic [31:0]       lsb_cdb_val_in;
    logic [ROB_W-1:0]  lsb_cdb_idx_in;
    // Issue to ALU
    logic              alu_flag_out;
    logic [5:0]        alu_op_out;
    logic [31:0]       alu_val1_out;
    logic [31:0]       alu_val2_out;
    logic [ROB_W-1:0]  alu_idx_in_ROB_out;

    modport master (
        output disp_flag_in, disp_op_in, disp_val1_in, disp_val2_in,
        output disp_rdy1_in, disp_rdy2_in, disp_q1_in, disp_q2_in, disp_idx_in_ROB_in,
        output alu_cdb_flag_in, alu_cdb_val_in, alu_cdb_idx_in,
        output lsb_cdb_flag_in, lsb_cdb_val_in, lsb_cdb_idx_in,
        input  full_out,
        input  alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out, alu_idx_in_ROB_out
    );

    modport slave (
        input  disp_flag_in, disp_op_in, disp_val1_in, disp_val2_in,
        input  disp_rdy1_in, disp_rdy2_in, disp_q1_in, disp_q2_in, disp_idx_in_ROB_in,
        input  alu_cdb_flag_in, alu_cdb_val_in, alu_cdb_idx_in,
        input  lsb_cdb_flag_in, lsb_cdb_val_in, lsb_cdb_idx_in,
        output full_out,
        output alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out, alu_idx_in_ROB_out
    );
endinterface

// File: rtl/reservation_station.sv
// Arithmetic reservation station: holds dispatched ALU/branch micro-ops, snoops the
// ALU and LSB result buses for missing operands and issues the lowest-index ready
// entry to the ALU each cycle through registered outputs.
module reservation_station #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_W   = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  rdy,
    input logic                  clear_in,
    reservation_station_if.slave rs
);
    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] rdy1_q, rdy1_d;
    logic [RS_SIZE-1:0] rdy2_q, rdy2_d;
    logic [5:0]         op_q   [RS_SIZE];
    logic [5:0]         op_d   [RS_SIZE];
    logic [31:0]        val1_q [RS_SIZE];
    logic [31:0]        val1_d [RS_SIZE];
    logic [31:0]        val2_q [RS_SIZE];
    logic [31:0]        val2_d [RS_SIZE];
    logic [ROB_W-1:0]   q1_q   [RS_SIZE];
    logic [ROB_W-1:0]   q1_d   [RS_SIZE];
    logic [ROB_W-1:0]   q2_q   [RS_SIZE];
    logic [ROB_W-1:0]   q2_d   [RS_SIZE];
    logic [ROB_W-1:0]   dest_q [RS_SIZE];
    logic [ROB_W-1:0]   dest_d [RS_SIZE];

    logic               flag_q, flag_d;
    logic [5:0]         out_op_q, out_op_d;
    logic [31:0]        out_val1_q, out_val1_d;
    logic [31:0]        out_val2_q, out_val2_d;
    logic [ROB_W-1:0]   out_idx_q, out_idx_d;

    logic               issue_found;
    logic [IdxW-1:0]    issue_idx;
    logic               free_found;
    logic [IdxW-1:0]    free_idx;

    // Returns {ready, value}: an operand still waiting on a tag picks up a matching
    // result-bus value; the ALU bus wins if both buses carry the same tag.
    function automatic logic [32:0] snoop(
        input logic             ready,
        input logic [31:0]      val,
        input logic [ROB_W-1:0] tag,
        input logic             a_flag,
        input logic [ROB_W-1:0] a_idx,
        input logic [31:0]      a_val,
        input logic             l_flag,
        input logic [ROB_W-1:0] l_idx,
        input logic [31:0]      l_val
    );
        logic [32:0] res;
        res = {ready, val};
        if (!ready) begin
            if (a_flag && (a_idx == tag)) begin
                res = {1'b1, a_val};
            end else if (l_flag && (l_idx == tag)) begin
                res = {1'b1, l_val};
            end
        end
        return res;
    endfunction

    // Lowest-index busy entry whose operands were both ready before this edge.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                issue_found = 1'b1;
                issue_idx   = IdxW'(i);
            end
        end
    end

    // Lowest-index free entry (pre-edge occupancy; a slot issued this edge is excluded).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // Next state: flush, else concurrent wake-up, issue and allocate.
    always_comb begin
        busy_d     = busy_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        op_d       = op_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        dest_d     = dest_q;
        flag_d     = 1'b0;
        out_op_d   = '0;
        out_val1_d = '0;
        out_val2_d = '0;
        out_idx_d  = '0;

        if (clear_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    {rdy1_d[i], val1_d[i]} = snoop(rdy1_q[i], val1_q[i], q1_q[i],
                        rs.alu_cdb_flag_in, rs.alu_cdb_idx_in, rs.alu_cdb_val_in,
                        rs.lsb_cdb_flag_in, rs.lsb_cdb_idx_in, rs.lsb_cdb_val_in);
                    {rdy2_d[i], val2_d[i]} = snoop(rdy2_q[i], val2_q[i], q2_q[i],
                        rs.alu_cdb_flag_in, rs.alu_cdb_idx_in, rs.alu_cdb_val_in,
                        rs.lsb_cdb_flag_in, rs.lsb_cdb_idx_in, rs.lsb_cdb_val_in);
                end
            end

            if (issue_found) begin
                flag_d            = 1'b1;
                out_op_d          = op_q[issue_idx];
                out_val1_d        = val1_q[issue_idx];
                out_val2_d        = val2_q[issue_idx];
                out_idx_d         = dest_q[issue_idx];
                busy_d[issue_idx] = 1'b0;
            end

            if (rs.disp_flag_in && free_found) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = rs.disp_op_in;
                q1_d[free_idx]   = rs.disp_q1_in;
                q2_d[free_idx]   = rs.disp_q2_in;
                dest_d[free_idx] = rs.disp_idx_in_ROB_in;
                {rdy1_d[free_idx], val1_d[free_idx]} = snoop(rs.disp_rdy1_in,
                    rs.disp_val1_in, rs.disp_q1_in,
                    rs.alu_cdb_flag_in, rs.alu_cdb_idx_in, rs.alu_cdb_val_in,
                    rs.lsb_cdb_flag_in, rs.lsb_cdb_idx_in, rs.lsb_cdb_val_in);
                {rdy2_d[free_idx], val2_d[free_idx]} = snoop(rs.disp_rdy2_in,
                    rs.disp_val2_in, rs.disp_q2_in,
                    rs.alu_cdb_flag_in, rs.alu_cdb_idx_in, rs.alu_cdb_val_in,
                    rs.lsb_cdb_flag_in, rs.lsb_cdb_idx_in, rs.lsb_cdb_val_in);
            end
        end
    end

    // State registers; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            flag_q     <= 1'b0;
            out_op_q   <= '0;
            out_val1_q <= '0;
            out_val2_q <= '0;
            out_idx_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                dest_q[i] <= '0;
            end
        end else if (rdy) begin
            busy_q     <= busy_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            flag_q     <= flag_d;
            out_op_q   <= out_op_d;
            out_val1_q <= out_val1_d;
            out_val2_q <= out_val2_d;
            out_idx_q  <= out_idx_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= op_d[i];
                val1_q[i] <= val1_d[i];
                val2_q[i] <= val2_d[i];
                q1_q[i]   <= q1_d[i];
                q2_q[i]   <= q2_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign rs.full_out           = &busy_q;
    assign rs.alu_flag_out       = flag_q;
    assign rs.alu_op_out         = out_op_q;
    assign rs.alu_val1_out       = out_val1_q;
    assign rs.alu_val2_out       = out_val2_q;
    assign rs.alu_idx_in_ROB_out = out_idx_q;
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a slot-level reference model predicts
// each issue (and the cycle it must appear), a monitor pops and compares.
module tb_reservation_station;
    localparam int unsigned RsSize = 8;
    localparam int unsigned RobW   = 4;
    localparam logic [5:0]  OpAdd  = 6'd1;
    localparam logic [5:0]  OpSub  = 6'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    logic clear_in = 1'b0;

    reservation_station_if #(.ROB_W(RobW)) rs_if ();

    reservation_station #(.RS_SIZE(RsSize), .ROB_W(RobW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clear_in (clear_in),
        .rs       (rs_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  tag;
    } issue_t;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        bit          r1;
        bit          r2;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic [3:0]  tag;
    } slot_t;

    issue_t      exp_q[$];
    slot_t       m[RsSize];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, cyc);
    endtask

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < RsSize; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    // Operand as seen after this edge: waiting operand takes a matching bus value.
    function automatic void resolve(input bit r, input logic [31:0] v, input logic [3:0] q,
                                    output bit r_o, output logic [31:0] v_o);
        r_o = r;
        v_o = v;
        if (!r && rs_if.alu_cdb_flag_in && rs_if.alu_cdb_idx_in == q) begin
            r_o = 1'b1; v_o = rs_if.alu_cdb_val_in;
        end else if (!r && rs_if.lsb_cdb_flag_in && rs_if.lsb_cdb_idx_in == q) begin
            r_o = 1'b1; v_o = rs_if.lsb_cdb_val_in;
        end
    endfunction

    // Applies the upcoming clock edge to the model using the inputs now on the pins.
    function automatic void model_edge();
        int     iss = -1;
        int     fr  = -1;
        issue_t it;
        if (!rdy) return;
        if (clear_in) begin
            for (int i = 0; i < RsSize; i++) m[i].busy = 1'b0;
            return;
        end
        for (int i = 0; i < RsSize; i++) begin
            if (iss < 0 && m[i].busy && m[i].r1 && m[i].r2) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        if (iss >= 0) begin
            it.cyc = cyc + 1;
            it.op  = m[iss].op;
            it.v1  = m[iss].v1;
            it.v2  = m[iss].v2;
            it.tag = m[iss].tag;
            exp_q.push_back(it);
        end
        for (int i = 0; i < RsSize; i++) begin
            if (m[i].busy) begin
                resolve(m[i].r1, m[i].v1, m[i].q1, m[i].r1, m[i].v1);
                resolve(m[i].r2, m[i].v2, m[i].q2, m[i].r2, m[i].v2);
            end
        end
        if (rs_if.disp_flag_in && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op   = rs_if.disp_op_in;
            m[fr].q1   = rs_if.disp_q1_in;
            m[fr].q2   = rs_if.disp_q2_in;
            m[fr].tag  = rs_if.disp_idx_in_ROB_in;
            resolve(rs_if.disp_rdy1_in, rs_if.disp_val1_in, rs_if.disp_q1_in, m[fr].r1, m[fr].v1);
            resolve(rs_if.disp_rdy2_in, rs_if.disp_val2_in, rs_if.disp_q2_in, m[fr].r2, m[fr].v2);
        end
        if (iss >= 0) m[iss].busy = 1'b0;
    endfunction

    task automatic set_idle();
        clear_in                 = 1'b0;
        rs_if.disp_flag_in       = 1'b0;
        rs_if.disp_op_in         = '0;
        rs_if.disp_val1_in       = '0;
        rs_if.disp_val2_in       = '0;
        rs_if.disp_rdy1_in       = 1'b0;
        rs_if.disp_rdy2_in       = 1'b0;
        rs_if.disp_q1_in         = '0;
        rs_if.disp_q2_in         = '0;
        rs_if.disp_idx_in_ROB_in = '0;
        rs_if.alu_cdb_flag_in    = 1'b0;
        rs_if.alu_cdb_val_in     = '0;
        rs_if.alu_cdb_idx_in     = '0;
        rs_if.lsb_cdb_flag_in    = 1'b0;
        rs_if.lsb_cdb_val_in     = '0;
        rs_if.lsb_cdb_idx_in     = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1, input bit r1,
                        input logic [3:0] q1, input logic [31:0] v2, input bit r2,
                        input logic [3:0] q2, input logic [3:0] tag);
        rs_if.disp_flag_in       = 1'b1;
        rs_if.disp_op_in         = op;
        rs_if.disp_val1_in       = v1;
        rs_if.disp_rdy1_in       = r1;
        rs_if.disp_q1_in         = q1;
        rs_if.disp_val2_in       = v2;
        rs_if.disp_rdy2_in       = r2;
        rs_if.disp_q2_in         = q2;
        rs_if.disp_idx_in_ROB_in = tag;
    endtask

    task automatic cdb_alu(input logic [3:0] idx, input logic [31:0] val);
        rs_if.alu_cdb_flag_in = 1'b1;
        rs_if.alu_cdb_idx_in  = idx;
        rs_if.alu_cdb_val_in  = val;
    endtask

    task automatic cdb_lsb(input logic [3:0] idx, input logic [31:0] val);
        rs_if.lsb_cdb_flag_in = 1'b1;
        rs_if.lsb_cdb_idx_in  = idx;
        rs_if.lsb_cdb_val_in  = val;
    endtask

    // Present current inputs for exactly one edge, then return to idle.
    task automatic tick();
        model_edge();
        @(negedge clk);
        set_idle();
    endtask

    // Monitor: every enabled edge either pops a predicted issue or expects none.
    bit     mon_en;
    bit     exp_flag;
    bit     last_flag = 1'b0;
    issue_t mon_it;
    issue_t last_it;
    always @(posedge clk) begin
        if (rst) begin
            mon_en = rdy;
            cyc    = cyc + 1;
            #2;
            if (mon_en) begin
                exp_flag = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                check("issue_flag", 32'(rs_if.alu_flag_out), 32'(exp_flag));
                if (exp_flag) begin
                    mon_it = exp_q.pop_front();
                    last_it = mon_it;
                    if (rs_if.alu_flag_out) begin
                        check("issue_op", 32'(rs_if.alu_op_out), 32'(mon_it.op));
                        check("issue_val1", rs_if.alu_val1_out, mon_it.v1);
                        check("issue_val2", rs_if.alu_val2_out, mon_it.v2);
                        check("issue_idx", 32'(rs_if.alu_idx_in_ROB_out), 32'(mon_it.tag));
                    end
                end
                last_flag = exp_flag;
            end else begin
                check("stall_flag", 32'(rs_if.alu_flag_out), 32'(last_flag));
                if (last_flag && rs_if.alu_flag_out) begin
                    check("stall_val1", rs_if.alu_val1_out, last_it.v1);
                    check("stall_idx", 32'(rs_if.alu_idx_in_ROB_out), 32'(last_it.tag));
                end
            end
            check("full", 32'(rs_if.full_out), 32'(m_full()));
        end
    end

    initial begin
        logic [3:0] ai;
        logic [3:0] li;
        for (int i = 0; i < RsSize; i++) m[i].busy = 1'b0;
        set_idle();
        repeat (3) @(negedge clk);
        check("reset_flag", 32'(rs_if.alu_flag_out), 32'd0);
        check("reset_full", 32'(rs_if.full_out), 32'd0);
        check("reset_op", 32'(rs_if.alu_op_out), 32'd0);
        check("reset_val1", rs_if.alu_val1_out, 32'd0);
        check("reset_val2", rs_if.alu_val2_out, 32'd0);
        check("reset_idx", 32'(rs_if.alu_idx_in_ROB_out), 32'd0);
        rst = 1'b1;
        rdy = 1'b1;

        // Ready ADD: issues one cycle after becoming eligible.
        disp(OpAdd, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
        repeat (3) tick();

        // SUB waits on tag 2, woken by the ALU bus.
        disp(OpSub, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 4'd4);
        repeat (2) tick();
        cdb_alu(4'd2, 32'd10);
        repeat (3) tick();

        // Dispatch-time bypass from the LSB bus.
        disp(OpAdd, 32'd3, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 4'd5);
        cdb_lsb(4'd6, 32'hDEADBEEF);
        repeat (3) tick();

        // Fill all slots with entries waiting on tag 9; extra dispatch is dropped.
        for (int i = 0; i < RsSize; i++) begin
            disp(6'(i + 3), 32'(i), 1'b0, 4'd9, 32'(100 + i), 1'b1, 4'd0, 4'(i));
            tick();
        end
        check("full_after_fill", 32'(rs_if.full_out), 32'd1);
        disp(OpAdd, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd8);
        tick();
        cdb_alu(4'd9, 32'h55AA);
        repeat (11) tick();

        // Flush with concurrent wake-up and dispatch.
        for (int i = 0; i < 3; i++) begin
            disp(OpSub, 32'd0, 1'b0, 4'd11, 32'(i), 1'b1, 4'd0, 4'(i + 1));
            tick();
        end
        clear_in = 1'b1;
        cdb_alu(4'd11, 32'h77);
        disp(OpAdd, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd12);
        tick();
        check("clear_flag", 32'(rs_if.alu_flag_out), 32'd0);
        check("clear_full", 32'(rs_if.full_out), 32'd0);
        cdb_alu(4'd11, 32'h78);
        repeat (3) tick();

        // Stall with ready entries and bus activity, then resume.
        for (int i = 0; i < 3; i++) begin
            disp(OpAdd, 32'(i * 7), 1'b1, 4'd0, 32'(i * 9), 1'b1, 4'd0, 4'(i + 5));
            tick();
        end
        disp(OpSub, 32'd0, 1'b0, 4'd13, 32'd4, 1'b1, 4'd0, 4'd14);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cdb_alu(4'd13, 32'h1234);
            disp(OpAdd, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 4'd15);
            tick();
        end
        rdy = 1'b1;
        cdb_lsb(4'd13, 32'h4321);
        repeat (6) tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom_range(9) != 0);
            if ($urandom_range(39) == 0) clear_in = 1'b1;
            if (!m_full() && $urandom_range(1) == 1) begin
                disp(6'($urandom_range(10)), $urandom, $urandom_range(2) != 0,
                     4'($urandom), $urandom, $urandom_range(2) != 0, 4'($urandom),
                     4'($urandom));
            end
            ai = 4'($urandom);
            li = 4'($urandom);
            if ($urandom_range(1) == 1) cdb_alu(ai, $urandom);
            if ($urandom_range(4) < 2 && !(rs_if.alu_cdb_flag_in && li == ai)) begin
                cdb_lsb(li, $urandom);
            end
            tick();
        end

        // Drain: sweep every tag on both buses until all entries issue.
        rdy = 1'b1;
        for (int n = 0; n < 48; n++) begin
            cdb_alu(4'(n), $urandom);
            cdb_lsb(4'(n + 8), $urandom);
            tick();
        end
        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("drained_full", 32'(rs_if.full_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
